id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register for the 5-stage RISC-V core, with load-use hazard detection and control-hazard squashing. It captures decoded operands and control from ID each cycle and presents them to EX. These include rs1/rs2 indices, rd and RegWrite, which the EX-stage forwarding logic consumes. It generates the PC/IF_ID stall and IF_ID flush controls, and keeps stall/flush event counters for performance debug.

## Interface
- XLEN, 32, datapath width (PC, operands, immediate)
- CNT_W, 32, width of stall/flush event counters

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch  in  1  control bits
- id_ALUctrl  in  4  ALU operation
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- ex_* (valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUctrl)  out  same widths as id_*  registered EX-stage fields
- PC_write  out  1  0 = hold PC
- IF_ID_write  out  1  0 = hold IF/ID register
- IF_ID_flush  out  1  1 = replace IF/ID contents with bubble
- stall_count, flush_count  out  CNT_W  event counters

## Operation
- Load-use hazard is combinational: `hazard = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Control hazard is `ex_branch_taken`.
- Update priority at each clk edge: rst > flush > stall > normal.
- rst: all ex_* outputs cleared to 0; both counters cleared to 0.
- flush (`ex_branch_taken`=1): load a bubble into ID/EX. A bubble is ex_valid=0 and all control bits (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch) = 0, with ALUctrl=0. Data and index fields are don't-care; implementation clears them to 0. flush_count increments.
- stall (hazard=1 and no flush): load a bubble into ID/EX. stall_count increments.
- normal: all ex_* fields take the id_* values. ex_valid takes id_valid. If id_valid=0, control bits are loaded as 0 regardless of the id_* control inputs.
- Combinational outputs:
  - PC_write = IF_ID_write = ~(hazard & ~ex_branch_taken)
  - IF_ID_flush = ex_branch_taken
- Flush wins over a simultaneous stall: the instruction in ID is wrong-path, so no stall is raised and only flush_count increments.
- Counters wrap modulo 2^CNT_W; they do not saturate.
- Register x0: an ex_rd of 0 never causes a stall.
- Unused source fields never cause a stall, e.g. rs2 of an I-type instruction.

## Timing
- Latency: id_* to ex_* is exactly 1 cycle.
- Stall/flush outputs are same-cycle combinational from current ex_* state and id_* inputs; there is no internal state machine beyond the register.
- A load followed by a dependent instruction produces exactly one bubble:
  - cycle N: hazard=1, PC_write=0.
  - cycle N+1: ex holds the bubble, the load has moved to MEM, hazard=0, and the consumer advances.
- Back-to-back loads with chained dependencies stall once per dependent pair.
- Reset asserted mid-stall: outputs are zeroed on the next edge. Because ex_valid=0 after reset, hazard=0 and PC_write=1 in the following cycle.
- Reset values:
  - all ex_* = 0
  - stall_count = flush_count = 0
  - with ex_* at 0: PC_write=1, IF_ID_write=1, IF_ID_flush = ex_branch_taken

## Test plan
- Reset: assert rst 2 cycles with random id_* inputs -> all ex_* = 0, both counts = 0, PC_write=1 after release.
- Pass-through: id_valid=1, id_pc=0x100, id_rd=5, RegWrite=1, ALUctrl=4'h2 -> next cycle ex_pc=0x100, ex_rd=5, ex_RegWrite=1, ex_ALUctrl=2; no stall.
- Load-use stall:
  - stimulus: `lw x6` in EX (ex_MemRead=1, ex_rd=6), ID `add x7,x6,x1` with rs1_used=1.
  - response: PC_write=IF_ID_write=0 for exactly 1 cycle, then a bubble in EX (ex_valid=0, ex_RegWrite=0), stall_count=1, and the add appears in EX one cycle later.
- No false stall: (a) ex_rd=0 with ex_MemRead=1 and id_rs1=0; (b) I-type with id_rs2=6 but id_rs2_used=0 and ex_rd=6 -> PC_write stays 1, stall_count unchanged.
- Flush vs. stall: a load-use condition and ex_branch_taken=1 in the same cycle -> IF_ID_flush=1, PC_write=1, bubble loaded, flush_count=1, stall_count=0.
- Counter wrap: with CNT_W=4, 16 consecutive flush cycles -> flush_count returns to 0.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: bundle between the ID stage, the ID/EX register and the
// EX-stage consumers.
//   master : ID-side driver (decoded fields, EX branch resolution) and
//            consumer of the EX fields, hazard controls and event counters.
//   slave  : the ID/EX register itself.
interface id_ex_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // ID-stage fields
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic            id_RegWrite;
    logic            id_MemRead;
    logic            id_MemWrite;
    logic            id_MemtoReg;
    logic            id_ALUSrc;
    logic            id_Branch;
    logic [3:0]      id_ALUctrl;
    logic            ex_branch_taken;

    // EX-stage fields
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_RegWrite;
    logic            ex_MemRead;
    logic            ex_MemWrite;
    logic            ex_MemtoReg;
    logic            ex_ALUSrc;
    logic            ex_Branch;
    logic [3:0]      ex_ALUctrl;

    // Front-end hazard controls and event counters
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
               id_ALUSrc, id_Branch, id_ALUctrl, ex_branch_taken,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch, ex_ALUctrl,
               PC_write, IF_ID_write, IF_ID_flush, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg,
               id_ALUSrc, id_Branch, id_ALUctrl, ex_branch_taken,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch, ex_ALUctrl,
               PC_write, IF_ID_write, IF_ID_flush, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register of the 5-stage RISC-V core.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : id_ex_pipe_if.slave
//              id_*            decoded instruction from ID (1-cycle to ex_*)
//              ex_branch_taken taken branch/jump resolved in EX
//              ex_*            registered EX-stage fields
//              PC_write, IF_ID_write, IF_ID_flush  front-end controls
//              stall_count, flush_count            wrapping event counters
// A load in EX whose destination is read by the instruction in ID inserts
// one bubble; a taken branch in EX squashes the ID instruction instead.
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic            valid_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] rs1_data_p1;
    logic [XLEN-1:0] rs2_data_p1;
    logic [XLEN-1:0] imm_p1;
    logic [4:0]      rs1_p1;
    logic [4:0]      rs2_p1;
    logic [4:0]      rd_p1;
    logic            reg_write_p1;
    logic            mem_read_p1;
    logic            mem_write_p1;
    logic            mem_to_reg_p1;
    logic            alu_src_p1;
    logic            branch_p1;
    logic [3:0]      alu_ctrl_p1;
    logic [CNT_W-1:0] stall_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;

    logic hazard;
    logic flush;
    logic bubble;
    logic ctrl_en;

    // ---- ID stage: hazard detection against the instruction now in EX ----
    // x0 is never a real dependency, and unused source fields are ignored
    // so that e.g. the rs2 slot of an I-type cannot stall.
    always_comb begin
        hazard = valid_p1 && mem_read_p1 && (rd_p1 != 5'd0) && bus.id_valid &&
                 ((bus.id_rs1_used && (bus.id_rs1 == rd_p1)) ||
                  (bus.id_rs2_used && (bus.id_rs2 == rd_p1)));
    end

    assign flush   = bus.ex_branch_taken;
    // The ID instruction is wrong-path on a flush, so its stall is dropped.
    assign bubble  = flush || hazard;
    assign ctrl_en = bus.id_valid;

    assign bus.PC_write    = ~(hazard & ~flush);
    assign bus.IF_ID_write = ~(hazard & ~flush);
    assign bus.IF_ID_flush = flush;

    // ---- ID/EX boundary ----
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_p1      <= 1'b0;
            pc_p1         <= '0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_src_p1    <= 1'b0;
            branch_p1     <= 1'b0;
            alu_ctrl_p1   <= '0;
        end else begin
            valid_p1      <= bus.id_valid;
            pc_p1         <= bus.id_pc;
            rs1_data_p1   <= bus.id_rs1_data;
            rs2_data_p1   <= bus.id_rs2_data;
            imm_p1        <= bus.id_imm;
            rs1_p1        <= bus.id_rs1;
            rs2_p1        <= bus.id_rs2;
            rd_p1         <= bus.id_rd;
            // An invalid ID slot must not carry side-effecting control.
            reg_write_p1  <= ctrl_en & bus.id_RegWrite;
            mem_read_p1   <= ctrl_en & bus.id_MemRead;
            mem_write_p1  <= ctrl_en & bus.id_MemWrite;
            mem_to_reg_p1 <= ctrl_en & bus.id_MemtoReg;
            alu_src_p1    <= ctrl_en & bus.id_ALUSrc;
            branch_p1     <= ctrl_en & bus.id_Branch;
            alu_ctrl_p1   <= ctrl_en ? bus.id_ALUctrl : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else if (flush) begin
            flush_cnt_p1 <= flush_cnt_p1 + CNT_ONE;
        end else if (hazard) begin
            stall_cnt_p1 <= stall_cnt_p1 + CNT_ONE;
        end
    end

    assign bus.ex_valid    = valid_p1;
    assign bus.ex_pc       = pc_p1;
    assign bus.ex_rs1_data = rs1_data_p1;
    assign bus.ex_rs2_data = rs2_data_p1;
    assign bus.ex_imm      = imm_p1;
    assign bus.ex_rs1      = rs1_p1;
    assign bus.ex_rs2      = rs2_p1;
    assign bus.ex_rd       = rd_p1;
    assign bus.ex_RegWrite = reg_write_p1;
    assign bus.ex_MemRead  = mem_read_p1;
    assign bus.ex_MemWrite = mem_write_p1;
    assign bus.ex_MemtoReg = mem_to_reg_p1;
    assign bus.ex_ALUSrc   = alu_src_p1;
    assign bus.ex_Branch   = branch_p1;
    assign bus.ex_ALUctrl  = alu_ctrl_p1;
    assign bus.stall_count = stall_cnt_p1;
    assign bus.flush_count = flush_cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed-vector bench for id_ex_pipe. A second instance
// with 4-bit counters shares the same inputs to exercise counter wrap.
module tb_id_ex_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_if #(.XLEN(32), .CNT_W(32)) bus ();
    id_ex_pipe_if #(.XLEN(32), .CNT_W(4))  sbus ();

    id_ex_pipe #(.XLEN(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_ex_pipe #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    assign sbus.id_valid        = bus.id_valid;
    assign sbus.id_pc           = bus.id_pc;
    assign sbus.id_rs1_data     = bus.id_rs1_data;
    assign sbus.id_rs2_data     = bus.id_rs2_data;
    assign sbus.id_imm          = bus.id_imm;
    assign sbus.id_rs1          = bus.id_rs1;
    assign sbus.id_rs2          = bus.id_rs2;
    assign sbus.id_rd           = bus.id_rd;
    assign sbus.id_rs1_used     = bus.id_rs1_used;
    assign sbus.id_rs2_used     = bus.id_rs2_used;
    assign sbus.id_RegWrite     = bus.id_RegWrite;
    assign sbus.id_MemRead      = bus.id_MemRead;
    assign sbus.id_MemWrite     = bus.id_MemWrite;
    assign sbus.id_MemtoReg     = bus.id_MemtoReg;
    assign sbus.id_ALUSrc       = bus.id_ALUSrc;
    assign sbus.id_Branch       = bus.id_Branch;
    assign sbus.id_ALUctrl      = bus.id_ALUctrl;
    assign sbus.ex_branch_taken = bus.ex_branch_taken;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one decoded instruction; load-style controls follow MemRead.
    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic rw,
                             input logic mr, input logic [3:0] alu);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1_data = pc + 32'h11;
        bus.id_rs2_data = pc + 32'h22;
        bus.id_imm      = 32'hFFFF_FFF0;
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
        bus.id_rd       = rd;
        bus.id_RegWrite = rw;
        bus.id_MemRead  = mr;
        bus.id_MemWrite = 1'b0;
        bus.id_MemtoReg = mr;
        bus.id_ALUSrc   = mr;
        bus.id_Branch   = 1'b0;
        bus.id_ALUctrl  = alu;
    endtask

    task automatic set_idle;
        set_instr(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0);
        bus.ex_branch_taken = 1'b0;
    endtask

    initial begin
        // ---- reset with random ID inputs ----
        rst = 1'b1;
        set_instr(1'b1, $urandom, 5'($urandom), 1'b1, 5'($urandom), 1'b1,
                  5'($urandom), 1'b1, 1'b1, 4'($urandom));
        bus.ex_branch_taken = 1'b0;
        step;
        step;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_pc", bus.ex_pc, 32'd0);
        chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_ex_RegWrite", 32'(bus.ex_RegWrite), 32'd0);
        chk("rst_ex_MemRead", 32'(bus.ex_MemRead), 32'd0);
        chk("rst_stall_count", bus.stall_count, 32'd0);
        chk("rst_flush_count", bus.flush_count, 32'd0);
        rst = 1'b0;
        set_idle;
        #1;
        chk("rst_PC_write", 32'(bus.PC_write), 32'd1);
        chk("rst_IF_ID_flush", 32'(bus.IF_ID_flush), 32'd0);

        // ---- pass-through ----
        set_instr(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 4'h2);
        #1;
        chk("pt_PC_write", 32'(bus.PC_write), 32'd1);
        step;
        chk("pt_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("pt_ex_pc", bus.ex_pc, 32'h100);
        chk("pt_ex_rs1_data", bus.ex_rs1_data, 32'h111);
        chk("pt_ex_imm", bus.ex_imm, 32'hFFFF_FFF0);
        chk("pt_ex_rd", 32'(bus.ex_rd), 32'd5);
        chk("pt_ex_RegWrite", 32'(bus.ex_RegWrite), 32'd1);
        chk("pt_ex_ALUctrl", 32'(bus.ex_ALUctrl), 32'd2);
        chk("pt_stall_count", bus.stall_count, 32'd0);

        // ---- invalid ID slot gates control bits ----
        set_instr(1'b0, 32'h104, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 4'h7);
        step;
        chk("inv_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("inv_ex_RegWrite", 32'(bus.ex_RegWrite), 32'd0);
        chk("inv_ex_MemRead", 32'(bus.ex_MemRead), 32'd0);
        chk("inv_ex_ALUctrl", 32'(bus.ex_ALUctrl), 32'd0);

        // ---- load-use stall: lw x6 then add x7,x6,x1 ----
        set_instr(1'b1, 32'h200, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 4'h0);
        step;
        chk("lu_load_in_ex", 32'(bus.ex_MemRead), 32'd1);
        set_instr(1'b1, 32'h204, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 4'h0);
        #1;
        chk("lu_PC_write", 32'(bus.PC_write), 32'd0);
        chk("lu_IF_ID_write", 32'(bus.IF_ID_write), 32'd0);
        chk("lu_IF_ID_flush", 32'(bus.IF_ID_flush), 32'd0);
        step;
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_RegWrite", 32'(bus.ex_RegWrite), 32'd0);
        chk("lu_bubble_MemRead", 32'(bus.ex_MemRead), 32'd0);
        chk("lu_stall_count", bus.stall_count, 32'd1);
        chk("lu_release_PC_write", 32'(bus.PC_write), 32'd1);
        step;
        chk("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_add_rd", 32'(bus.ex_rd), 32'd7);
        chk("lu_add_rs1", 32'(bus.ex_rs1), 32'd6);
        chk("lu_add_pc", bus.ex_pc, 32'h204);
        chk("lu_stall_once", bus.stall_count, 32'd1);

        // ---- no false stall: (a) x0 destination, (b) unused rs2 ----
        set_instr(1'b1, 32'h300, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 4'h0);
        step;
        set_instr(1'b1, 32'h304, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 4'h0);
        #1;
        chk("nfs_x0_PC_write", 32'(bus.PC_write), 32'd1);
        step;
        set_instr(1'b1, 32'h308, 5'd3, 1'b1, 5'd6, 1'b0, 5'd8, 1'b1, 1'b0, 4'h0);
        #1;
        chk("nfs_unused_PC_write", 32'(bus.PC_write), 32'd1);
        step;
        chk("nfs_stall_count", bus.stall_count, 32'd1);
        chk("nfs_ex_rd", 32'(bus.ex_rd), 32'd8);

        // ---- flush vs stall, from a fresh reset ----
        rst = 1'b1;
        set_idle;
        step;
        rst = 1'b0;
        set_instr(1'b1, 32'h400, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 4'h0);
        step;
        set_instr(1'b1, 32'h404, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 4'h3);
        bus.ex_branch_taken = 1'b1;
        #1;
        chk("fvs_IF_ID_flush", 32'(bus.IF_ID_flush), 32'd1);
        chk("fvs_PC_write", 32'(bus.PC_write), 32'd1);
        chk("fvs_IF_ID_write", 32'(bus.IF_ID_write), 32'd1);
        step;
        chk("fvs_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("fvs_bubble_ALUctrl", 32'(bus.ex_ALUctrl), 32'd0);
        chk("fvs_flush_count", bus.flush_count, 32'd1);
        chk("fvs_stall_count", bus.stall_count, 32'd0);

        // ---- counter wrap: 16 consecutive flushes from reset ----
        rst = 1'b1;
        set_idle;
        step;
        rst = 1'b0;
        bus.ex_branch_taken = 1'b1;
        for (int i = 0; i < 15; i++) step;
        chk("wrap_small_15", 32'(sbus.flush_count), 32'd15);
        step;
        chk("wrap_small_0", 32'(sbus.flush_count), 32'd0);
        chk("wrap_wide_16", bus.flush_count, 32'd16);
        bus.ex_branch_taken = 1'b0;

        // ---- reset asserted mid-stall ----
        set_instr(1'b1, 32'h500, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 4'h0);
        step;
        set_instr(1'b1, 32'h504, 5'd4, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 4'h0);
        #1;
        chk("mrs_hazard_PC_write", 32'(bus.PC_write), 32'd0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        chk("mrs_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("mrs_PC_write", 32'(bus.PC_write), 32'd1);
        chk("mrs_stall_count", bus.stall_count, 32'd0);
        chk("mrs_flush_count", bus.flush_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end

endmodule
